// File: rtl/spi_sched_pkg.sv
// Shared types and default constants for the SPI transmit scheduler.
// DATA_WIDTH comes from the project-wide defines and falls back to 8 if unset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package spi_sched_pkg;

    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int DEF_CS_SETUP   = 2;
    localparam int DEF_CS_HOLD    = 2;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } sched_state_e;

    // Down-counters terminate at zero, so an N-cycle phase loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational rotating-priority encoder: the first requester after
// last_grant_i (wrapping) wins.
module spi_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] last_grant_i,
    output logic [$clog2(NUM_CH)-1:0] grant_o,
    output logic                      valid_o
);

    int unsigned idx;

    always_comb begin
        grant_o = last_grant_i;
        valid_o = 1'b0;
        idx     = 0;
        // Scan farthest to nearest so the nearest requester is written last.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % NUM_CH;
            if (req_i[idx]) begin
                grant_o = $clog2(NUM_CH)'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler feeding one SPI serializer from NUM_CH FIFOs, one word per grant.
// Optional XFER watchdog enabled by the SPI_SCHED_TIMEOUT_EN macro.
module spi_tx_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATAWIDTH = `DATA_WIDTH,
    parameter int CS_SETUP  = DEF_CS_SETUP,
    parameter int CS_HOLD   = DEF_CS_HOLD
`ifdef SPI_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_empty,
    input  logic [NUM_CH*DATAWIDTH-1:0] ch_rdata,
    output logic [NUM_CH-1:0]           ch_pop,
    output logic [DATAWIDTH-1:0]        ser_data,
    output logic                        ser_start,
    input  logic                        ser_done,
    output logic [NUM_CH-1:0]           cs_n,
    output logic [$clog2(NUM_CH)-1:0]   grant_id,
    output logic                        busy
`ifdef SPI_SCHED_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);

    localparam int GW = $clog2(NUM_CH);

    sched_state_e         state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_q, last_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 start_q, start_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]        arb_grant;
    logic                 arb_valid;
    logic [NUM_CH-1:0]    grant_oh;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            terr_q, terr_d;
`endif

    spi_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i        (~ch_empty),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
            data_q  <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            to_q    <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            to_q    <= to_d;
            terr_q  <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
`ifdef SPI_SCHED_TIMEOUT_EN
        to_d    = to_q;
        terr_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                data_d  = ch_rdata[int'(grant_q)*DATAWIDTH +: DATAWIDTH];
                cnt_d   = cnt_load(CS_SETUP);
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    start_d = 1'b1;
                    state_d = ST_XFER;
`ifdef SPI_SCHED_TIMEOUT_EN
                    to_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_XFER: begin
                // A done pulse coincident with our own start belongs to a previous word.
                if (ser_done && !start_q) begin
                    cnt_d   = cnt_load(CS_HOLD);
                    state_d = ST_HOLD;
                end
`ifdef SPI_SCHED_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    cnt_d   = cnt_load(CS_HOLD);
                    state_d = ST_HOLD;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // Masking with ~ch_empty guarantees no pop ever reaches an empty FIFO.
    assign ch_pop    = (state_q == ST_POP) ? (grant_oh & ~ch_empty) : '0;
    assign cs_n      = (state_q == ST_IDLE) ? '1 : ~grant_oh;
    assign busy      = (state_q != ST_IDLE);
    assign ser_start = start_q;
    assign ser_data  = data_q;
    assign grant_id  = grant_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

endmodule

// File: doc/spi_tx_scheduler.md
SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requester FIFOs sharing one SPI serializer (2..8).
REQ-002 Parameter DATAWIDTH, default `DATA_WIDTH: word width.
REQ-003 Parameter CS_SETUP, default 2: clk cycles cs_n low before ser_start.
REQ-004 Parameter CS_HOLD, default 2: clk cycles cs_n held low after ser_done.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ch_empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-008 ch_rdata  input  NUM_CH*DATAWIDTH  per-channel FIFO head word (first-word-fall-through); channel i at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-009 ch_pop  output  NUM_CH  one-hot single-cycle FIFO read strobe.
REQ-010 ser_data  output  DATAWIDTH  word presented to serializer, stable from ser_start until ser_done.
REQ-011 ser_start  output  1  one-cycle start pulse to serializer.
REQ-012 ser_done  input  1  serializer completion pulse.
REQ-013 cs_n  output  NUM_CH  active-low chip selects, at most one low.
REQ-014 grant_id  output  $clog2(NUM_CH)  channel currently owning the serializer.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, POP, SETUP, XFER, HOLD; the state register advances every clk.
REQ-017 IDLE: if any ch_empty bit low, select the granted channel by round-robin starting at (last_grant+1) mod NUM_CH, latch it to grant_id, go to POP; otherwise stay in IDLE.
REQ-018 POP (1 cycle): ch_pop[grant_id]=1, latch ch_rdata[grant_id] into ser_data, drive cs_n[grant_id] low, load setup counter, go to SETUP.
REQ-019 SETUP: hold for CS_SETUP cycles, then assert ser_start for exactly one cycle and go to XFER.
REQ-020 XFER: wait for ser_done; a ser_done in the ser_start cycle is ignored; on ser_done load hold counter, go to HOLD.
REQ-021 HOLD: keep cs_n low CS_HOLD cycles, then drive all cs_n high, set last_grant=grant_id, go to IDLE.
REQ-022 Latency: ser_start rises exactly 1+CS_SETUP cycles after the IDLE->POP decision edge.
REQ-023 Only one word is transferred per grant; back-to-back words on one channel re-arbitrate each time.
REQ-024 A channel whose ch_empty rises after the grant does not cancel the transfer (the word is already latched).
REQ-025 Round-robin wraps from NUM_CH-1 to 0; with a single requester that channel is granted every time.
REQ-026 ch_pop never asserts for a channel with ch_empty high.
REQ-027 ser_done outside XFER is ignored.

Reset
REQ-028 On rst: state=IDLE, ch_pop=0, ser_start=0, ser_data=0, cs_n all 1, grant_id=0, last_grant=NUM_CH-1 (so channel 0 has first priority), busy=0, counters=0.
REQ-029 rst asserted mid-transfer aborts immediately to reset values; no pending pop or start is replayed.

Configuration
REQ-030 Macro SPI_SCHED_TIMEOUT_EN: when defined, parameter TIMEOUT (default 1024) bounds XFER; if ser_done is absent for TIMEOUT cycles, output timeout_err pulses 1 cycle and the FSM proceeds to HOLD as if done.
REQ-031 Without SPI_SCHED_TIMEOUT_EN, the timeout_err port and the timeout counter do not exist and XFER waits indefinitely.

Structure
REQ-032 Package spi_sched_pkg holds the state typedef, default CS_SETUP/CS_HOLD/TIMEOUT constants, and reuses `DATA_WIDTH from spi_defines.svh.
REQ-033 Sub-module spi_rr_arbiter: combinational rotating-priority encoder (inputs req, last_grant; outputs grant index, valid), instantiated once.

Verification
REQ-034 Only ch1 non-empty, head 0xA5, CS_SETUP=2 -> ch_pop[1] pulses once, cs_n=4'b1101, ser_data=0xA5, ser_start 3 cycles after grant.
REQ-035 All 4 channels non-empty after reset -> grant order 0,1,2,3,0 across five transfers.
REQ-036 ser_done 10 cycles after ser_start, CS_HOLD=2 -> cs_n returns to 4'b1111 exactly 2 cycles after ser_done, busy falls the same cycle.
REQ-037 rst pulsed while in XFER on ch2 -> next cycle cs_n=4'b1111, busy=0, ser_start=0; no extra ch_pop.
REQ-038 SPI_SCHED_TIMEOUT_EN, TIMEOUT=16, ser_done never asserted -> timeout_err pulses 16 cycles after ser_start, FSM reaches IDLE after CS_HOLD.
REQ-039 Spurious ser_done in IDLE and in the ser_start cycle -> no state change, transfer still waits for the next ser_done.
